mont_lsu_port: RTL and testbench
================================

# mont_lsu_port

Memory-side responder for the Montgomery multiplier's LSU request interface. Resolves each accelerator request, selected base register plus byte offset, into a data-memory transaction on a req/gnt/rvalid bus. Reads return one word with a single-cycle done pulse. Writes are posted into a small buffer so the accelerator can issue one write per cycle without waiting. Sits between the accelerator and the core's data-memory arbiter; the core loads the base registers when it decodes the custom instruction.

## Interface
- WBUF_DEPTH, 4: posted-write buffer entries, power of two, must be ≥ accelerator WORDS.
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- base_we  in  1  load a base register this cycle.
- base_sel  in  2  base register index 0..3 (3 = result pointer).
- base_data  in  32  base address value.
- acc_ren  in  1  read request, held until acc_done.
- acc_wen  in  1  write request, one posted write per high cycle.
- acc_type  in  2  access size code: DATA_WORD, DATA_HALFWORD or DATA_BYTE.
- acc_addr_offset  in  32  byte offset added to the selected base.
- acc_op_sel  in  2  base register index for this request.
- acc_wdata  in  32  write data.
- acc_done  out  1  one-cycle read completion pulse.
- acc_rdata  out  32  read data, valid only while acc_done is high.
- dmem_req, dmem_we  out  1  memory request and write enable.
- dmem_addr  out  32  word-aligned address.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  memory write data.
- dmem_gnt, dmem_rvalid  in  1  memory grant and read-data-valid.
- dmem_rdata  in  32  memory read data.
- wbuf_overflow  out  1  sticky; set when a write arrives while the buffer is full.
- idle  out  1  high when FSM is IDLE, buffer is empty and acc_ren is low.

## Operation
- Address: addr = base[acc_op_sel] + acc_offset, modulo 2^32.
  - dmem_addr = {addr[31:2], 2'b00}.
  - addr[1:0] selects the byte lanes.
- Base registers:
  - Written when base_we is high.
  - A write to index k takes effect on the next cycle; it is not forwarded to a request in the same cycle.
- Posted writes:
  - On any cycle with acc_wen high and the buffer not full, push {addr, wdata, be}. This happens in every FSM state.
  - If the buffer is full, the write is dropped and wbuf_overflow is set. Only rst clears the flag.
  - If acc_wen and acc_ren are both high, the write is pushed and the read is ignored that cycle.
- FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_DONE.
  - IDLE → WR_REQ when the buffer is not empty. Writes drain before reads, so a read always observes earlier writes.
  - IDLE → RD_REQ when acc_ren is high, the buffer is empty and no push occurs this cycle. The read address is latched on entry.
  - WR_REQ: drive dmem_req=1, dmem_we=1 from the buffer head. On dmem_gnt, pop the head. Go to IDLE if the buffer then becomes empty; otherwise stay in WR_REQ.
  - RD_REQ: drive dmem_req=1, dmem_we=0. On dmem_gnt go to RD_WAIT.
  - RD_WAIT: on dmem_rvalid, register the aligned/extended data and go to RD_DONE.
  - RD_DONE: acc_done=1. Requests are ignored in this state. Next state is IDLE.
- The accelerator may hold acc_ren high across RD_DONE with a new offset. That request is sampled in the following IDLE cycle.

## Timing
- Reset values:
  - All outputs 0, except idle, which is 1.
  - Base registers 0, buffer empty, FSM in IDLE.
- Read latency with dmem_gnt and dmem_rvalid asserted at the first opportunity:
  - acc_ren sampled in IDLE at cycle t.
  - dmem_req high at t+1.
  - dmem_rvalid at t+2.
  - acc_done at t+3.
  - Next read is sampled at t+4.
- Write throughput:
  - One push per cycle.
  - Drain is one word per granted cycle. A push and a pop may occur in the same cycle; the occupancy is then unchanged.
- dmem_req/addr/we/be/wdata are registered outputs. They stay stable until dmem_gnt.
- rst mid-transaction:
  - FSM returns to IDLE, the buffer is flushed and dmem_req drops immediately.
  - Any outstanding rvalid after reset is ignored.

## Configuration
- MONT_LSU_SUBWORD_EN defined:
  - acc_type is honoured.
  - Halfword and byte writes replicate data across lanes and set the matching dmem_be.
  - Halfword and byte reads shift the addressed lane down to bit 0 and zero-extend it.
- MONT_LSU_SUBWORD_EN undefined:
  - acc_type is ignored, dmem_be = 4'hF and addr[1:0] is ignored.
  - Read data is passed through unchanged.

## Structure
- Shared package mont_lsu_pkg holds:
  - the FSM state enum;
  - base index constants (result = 3);
  - the access-type codes, matching the core's DATA_WORD/DATA_HALFWORD/DATA_BYTE;
  - the byte-enable helper function.
- Sub-module mont_lsu_wbuf: synchronous FIFO, WBUF_DEPTH × 68 bits ({addr, wdata, be}). Provides push, pop, full, empty and the head entry.
- The top level holds the base registers, address adder, FSM and read-data alignment.

## Test plan
- Single read, with base[1]=0x1000, offset 0x8 and mem[0x1008]=0xDEADBEEF:
  - dmem_addr=0x1008, acc_done exactly 3 cycles after acc_ren, acc_rdata=0xDEADBEEF.
- Back-to-back reads with acc_ren held high, offsets 0, 4, 8, 12 applied in each done cycle:
  - four dmem reads at ascending addresses, four done pulses, 4 cycles apart.
- Four consecutive write cycles to base[3]=0x2000, data 1..4, dmem_gnt delayed by 2 cycles:
  - all four words land at 0x2000..0x200C in order, no overflow, idle rises afterwards.
- Read issued while 2 writes are pending to the same address:
  - the read is issued only after both writes are granted, and returns the second write's data.
- WBUF_DEPTH+1 writes with dmem_gnt held low: wbuf_overflow=1, and the first WBUF_DEPTH entries still drain correctly.
- Reset asserted in RD_WAIT: dmem_req and acc_done are 0 and idle=1, and a later rvalid produces no done pulse.

Source files
------------

// File: rtl/mont_lsu_pkg.sv
// Shared FSM states, base-register indices, access-size codes and the byte-enable
// helper used by the Montgomery multiplier LSU port.
package mont_lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_RD_DONE
   } lsu_state_e;

   localparam logic [1:0] BASE_OP_A   = 2'd0;
   localparam logic [1:0] BASE_OP_B   = 2'd1;
   localparam logic [1:0] BASE_MOD    = 2'd2;
   localparam logic [1:0] BASE_RESULT = 2'd3;

   // Same encoding as the core's load/store size field.
   localparam logic [1:0] DATA_WORD     = 2'b00;
   localparam logic [1:0] DATA_HALFWORD = 2'b01;
   localparam logic [1:0] DATA_BYTE     = 2'b10;

   localparam int WBUF_ENTRY_W = 68;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } wbuf_entry_t;

   function automatic logic [3:0] byte_enable(input logic [1:0] acc_type,
                                              input logic [1:0] lane);
      case (acc_type)
         DATA_BYTE:     byte_enable = 4'b0001 << lane;
         DATA_HALFWORD: byte_enable = lane[1] ? 4'b1100 : 4'b0011;
         default:       byte_enable = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/mont_lsu_wbuf.sv
// Posted-write FIFO for the LSU port: DEPTH entries of {addr, wdata, be}.
// Exposes the head and the entry behind it so the drain can issue back-to-back.
module mont_lsu_wbuf
   import mont_lsu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WBUF_ENTRY_W-1:0] push_data,
   output logic                    full,
   output logic                    empty,
   output logic                    last,
   output logic [WBUF_ENTRY_W-1:0] head,
   output logic [WBUF_ENTRY_W-1:0] second
);

   localparam int AW = $clog2(DEPTH);

   logic [WBUF_ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [AW-1:0]           rd_ptr_nxt;
   logic [AW:0]             count;
   logic                    do_push;
   logic                    do_pop;

   assign do_push    = push && !full;
   assign do_pop     = pop && !empty;
   assign rd_ptr_nxt = rd_ptr + AW'(1);

   assign full   = (count == (AW+1)'(DEPTH));
   assign empty  = (count == '0);
   assign last   = (count == (AW+1)'(1));
   assign head   = mem[rd_ptr];
   assign second = mem[rd_ptr_nxt];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of the order processes are evaluated in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr_nxt;
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers and count
   // define which entries are valid, so a flush only needs to clear those.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mont_lsu_port.sv
// LSU responder for the Montgomery multiplier: base+offset addressing, posted writes,
// single-word reads. Define MONT_LSU_SUBWORD_EN to honour halfword/byte accesses.
module mont_lsu_port
   import mont_lsu_pkg::*;
#(
   parameter int WBUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        base_we,
   input  logic [1:0]  base_sel,
   input  logic [31:0] base_data,
   input  logic        acc_ren,
   input  logic        acc_wen,
   input  logic [1:0]  acc_type,
   input  logic [31:0] acc_addr_offset,
   input  logic [1:0]  acc_op_sel,
   input  logic [31:0] acc_wdata,
   output logic        acc_done,
   output logic [31:0] acc_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        wbuf_overflow,
   output logic        idle
);

   lsu_state_e  state_q, state_d;
   logic [31:0] base_q [4];
   logic [31:0] addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic [31:0] rd_aligned;

   logic        push, pop;
   logic        wbuf_full, wbuf_empty, wbuf_last;
   wbuf_entry_t push_entry, head_e, second_e;

   logic        req_d, we_d, rd_capture;
   logic [31:0] addr_d, wdata_d;
   logic [3:0]  be_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) base_q[i] <= '0;
      end else if (base_we) begin
         base_q[base_sel] <= base_data;
      end
   end

   assign addr = base_q[acc_op_sel] + acc_addr_offset;

`ifdef MONT_LSU_SUBWORD_EN
   logic [1:0]  rd_lane_q, rd_type_q;
   logic [31:0] rd_shifted;

   assign req_be = byte_enable(acc_type, addr[1:0]);

   always_comb begin
      case (acc_type)
         DATA_BYTE:     req_wdata = {4{acc_wdata[7:0]}};
         DATA_HALFWORD: req_wdata = {2{acc_wdata[15:0]}};
         default:       req_wdata = acc_wdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_lane_q <= '0;
         rd_type_q <= DATA_WORD;
      end else if (state_q == ST_IDLE && state_d == ST_RD_REQ) begin
         rd_lane_q <= addr[1:0];
         rd_type_q <= acc_type;
      end
   end

   always_comb begin
      rd_shifted = dmem_rdata >> {rd_lane_q, 3'b000};
      case (rd_type_q)
         DATA_BYTE:     rd_aligned = {24'h0, rd_shifted[7:0]};
         DATA_HALFWORD: rd_aligned = {16'h0, rd_shifted[15:0]};
         default:       rd_aligned = dmem_rdata;
      endcase
   end
`else
   logic unused_subword;

   assign req_be         = 4'hF;
   assign req_wdata      = acc_wdata;
   assign rd_aligned     = dmem_rdata;
   assign unused_subword = ^{acc_type, addr[1:0]};
`endif

   assign push       = acc_wen && !wbuf_full;
   assign push_entry = '{addr: {addr[31:2], 2'b00}, wdata: req_wdata, be: req_be};

   mont_lsu_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (push_entry),
      .full      (wbuf_full),
      .empty     (wbuf_empty),
      .last      (wbuf_last),
      .head      (head_e),
      .second    (second_e)
   );

   // NOTE: every signal driven here gets a default first, so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      rd_capture = 1'b0;
      req_d      = dmem_req;
      we_d       = dmem_we;
      addr_d     = dmem_addr;
      be_d       = dmem_be;
      wdata_d    = dmem_wdata;
      case (state_q)
         ST_IDLE: begin
            if (!wbuf_empty) begin
               state_d = ST_WR_REQ;
               req_d   = 1'b1;
               we_d    = 1'b1;
               addr_d  = head_e.addr;
               wdata_d = head_e.wdata;
               be_d    = head_e.be;
            end else if (acc_ren && !push) begin
               state_d = ST_RD_REQ;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = {addr[31:2], 2'b00};
               be_d    = req_be;
            end
         end
         ST_WR_REQ: begin
            if (dmem_gnt) begin
               pop = 1'b1;
               if (wbuf_last && !push) begin
                  state_d = ST_IDLE;
                  req_d   = 1'b0;
                  we_d    = 1'b0;
               end else begin
                  // The next head is either the queued entry behind the current one,
                  // or the entry being pushed this very cycle.
                  addr_d  = wbuf_last ? push_entry.addr  : second_e.addr;
                  wdata_d = wbuf_last ? push_entry.wdata : second_e.wdata;
                  be_d    = wbuf_last ? push_entry.be    : second_e.be;
               end
            end
         end
         ST_RD_REQ: begin
            if (dmem_gnt) begin
               state_d = ST_RD_WAIT;
               req_d   = 1'b0;
            end
         end
         ST_RD_WAIT: begin
            if (dmem_rvalid) begin
               state_d    = ST_RD_DONE;
               rd_capture = 1'b1;
            end
         end
         ST_RD_DONE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_be       <= '0;
         dmem_wdata    <= '0;
         acc_rdata     <= '0;
         wbuf_overflow <= 1'b0;
      end else begin
         state_q    <= state_d;
         dmem_req   <= req_d;
         dmem_we    <= we_d;
         dmem_addr  <= addr_d;
         dmem_be    <= be_d;
         dmem_wdata <= wdata_d;
         if (rd_capture)           acc_rdata     <= rd_aligned;
         if (acc_wen && wbuf_full) wbuf_overflow <= 1'b1;
      end
   end

   assign acc_done = (state_q == ST_RD_DONE);
   assign idle     = (state_q == ST_IDLE) && wbuf_empty && !acc_ren;

endmodule

// File: tb/tb_mont_lsu_port.sv
// Directed bench for mont_lsu_port (default word-only build) with a small
// req/gnt/rvalid memory model whose grant delay and rvalid release are steerable.
`timescale 1ns/1ps
module tb_mont_lsu_port;

   localparam int WBUF_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        base_we;
   logic [1:0]  base_sel;
   logic [31:0] base_data;
   logic        acc_ren, acc_wen;
   logic [1:0]  acc_type;
   logic [31:0] acc_addr_offset;
   logic [1:0]  acc_op_sel;
   logic [31:0] acc_wdata;
   logic        acc_done;
   logic [31:0] acc_rdata;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        wbuf_overflow, idle;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mont_lsu_port #(.WBUF_DEPTH(WBUF_DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .base_we         (base_we),
      .base_sel        (base_sel),
      .base_data       (base_data),
      .acc_ren         (acc_ren),
      .acc_wen         (acc_wen),
      .acc_type        (acc_type),
      .acc_addr_offset (acc_addr_offset),
      .acc_op_sel      (acc_op_sel),
      .acc_wdata       (acc_wdata),
      .acc_done        (acc_done),
      .acc_rdata       (acc_rdata),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_be         (dmem_be),
      .dmem_wdata      (dmem_wdata),
      .dmem_gnt        (dmem_gnt),
      .dmem_rvalid     (dmem_rvalid),
      .dmem_rdata      (dmem_rdata),
      .wbuf_overflow   (wbuf_overflow),
      .idle            (idle)
   );

   // Memory model: word array, write/read logs, grant after gnt_delay waiting cycles.
   logic [31:0] mem [4096];
   logic [31:0] wlog_addr[$];
   logic [31:0] wlog_data[$];
   logic [31:0] rlog_addr[$];
   int          rd_after_writes = 0;
   int          gnt_delay = 0;
   int          wait_cnt = 0;
   logic        gnt_en = 1'b1;
   logic        rvalid_en = 1'b1;
   logic        rd_pend = 1'b0;
   logic [31:0] rd_pend_addr = '0;

   assign dmem_gnt = dmem_req && gnt_en && (wait_cnt >= gnt_delay);

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      dmem_rvalid <= 1'b0;
      if (dmem_req && dmem_gnt) begin
         wait_cnt <= 0;
         if (dmem_we) begin
            mem[dmem_addr[13:2]] <= merge(mem[dmem_addr[13:2]], dmem_wdata, dmem_be);
            wlog_addr.push_back(dmem_addr);
            wlog_data.push_back(dmem_wdata);
         end else begin
            rlog_addr.push_back(dmem_addr);
            rd_after_writes <= wlog_addr.size();
            if (rvalid_en) begin
               dmem_rvalid <= 1'b1;
               dmem_rdata  <= mem[dmem_addr[13:2]];
            end else begin
               rd_pend      <= 1'b1;
               rd_pend_addr <= dmem_addr;
            end
         end
      end else begin
         if (dmem_req) wait_cnt <= wait_cnt + 1;
         if (rd_pend && rvalid_en) begin
            dmem_rvalid <= 1'b1;
            dmem_rdata  <= mem[rd_pend_addr[13:2]];
            rd_pend     <= 1'b0;
         end
      end
   end

   task automatic set_base(input logic [1:0] sel, input logic [31:0] val);
      @(negedge clk);
      base_we   = 1'b1;
      base_sel  = sel;
      base_data = val;
      @(negedge clk);
      base_we   = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", dmem_req); end
      vectors++; if (dmem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b exp 0", dmem_we); end
      vectors++; if (dmem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", dmem_addr); end
      vectors++; if (dmem_be !== 4'h0) begin miscompares++; $display("FAIL reset_be got %h exp 0", dmem_be); end
      vectors++; if (dmem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata got %h exp 0", dmem_wdata); end
      vectors++; if (acc_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", acc_done); end
      vectors++; if (acc_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", acc_rdata); end
      vectors++; if (wbuf_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b exp 0", wbuf_overflow); end
      vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle got %b exp 1", idle); end
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      logic        seen_req, seen_done;
      logic [31:0] got_addr, got_data;
      int          lat;
      set_base(2'd1, 32'h0000_1000);
      mem[32'h1008 >> 2] <= 32'hDEAD_BEEF;
      acc_op_sel      = 2'd1;
      acc_addr_offset = 32'h8;
      acc_ren         = 1'b1;
      seen_req = 1'b0; seen_done = 1'b0; got_addr = '0; got_data = '0; lat = 0;
      for (int k = 1; k <= 20 && !seen_done; k++) begin
         @(negedge clk);
         if (dmem_req && !dmem_we && !seen_req) begin seen_req = 1'b1; got_addr = dmem_addr; end
         if (acc_done) begin seen_done = 1'b1; lat = k; got_data = acc_rdata; end
      end
      acc_ren = 1'b0;
      vectors++; if (seen_done !== 1'b1) begin miscompares++; $display("FAIL rd_timeout got %b exp 1", seen_done); end
      vectors++; if (got_addr !== 32'h0000_1008) begin miscompares++; $display("FAIL rd_addr got %h exp 00001008", got_addr); end
      vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rd_latency got %0d exp 3", lat); end
      vectors++; if (got_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_data got %h exp deadbeef", got_data); end
   endtask

   task automatic test_back_to_back();
      int t_done[4];
      int rbase;
      logic seen;
      for (int i = 0; i < 4; i++) mem[(32'h1000 >> 2) + i] <= 32'h1111_0000 + 32'(i);
      rbase = rlog_addr.size();
      @(negedge clk);
      acc_op_sel      = 2'd1;
      acc_addr_offset = 32'h0;
      acc_ren         = 1'b1;
      for (int i = 0; i < 4; i++) begin
         seen = 1'b0;
         for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (acc_done) seen = 1'b1;
         end
         t_done[i] = cyc;
         vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL b2b_timeout_%0d got %b exp 1", i, seen); end
         vectors++; if (acc_rdata !== 32'h1111_0000 + 32'(i)) begin miscompares++; $display("FAIL b2b_data_%0d got %h exp %h", i, acc_rdata, 32'h1111_0000 + 32'(i)); end
         if (i < 3) acc_addr_offset = 32'(4 * (i + 1));
         else       acc_ren = 1'b0;
      end
      vectors++; if (rlog_addr.size() - rbase !== 4) begin miscompares++; $display("FAIL b2b_reads got %0d exp 4", rlog_addr.size() - rbase); end
      for (int i = 0; i < 4 && rbase + i < rlog_addr.size(); i++) begin
         vectors++; if (rlog_addr[rbase + i] !== 32'h1000 + 32'(4 * i)) begin miscompares++; $display("FAIL b2b_addr_%0d got %h exp %h", i, rlog_addr[rbase + i], 32'h1000 + 32'(4 * i)); end
      end
      for (int i = 1; i < 4; i++) begin
         vectors++; if (t_done[i] - t_done[i-1] !== 4) begin miscompares++; $display("FAIL b2b_spacing_%0d got %0d exp 4", i, t_done[i] - t_done[i-1]); end
      end
   endtask

   task automatic test_write_burst();
      int   wbase;
      logic done_idle;
      set_base(2'd3, 32'h0000_2000);
      gnt_delay = 2;
      wbase = wlog_addr.size();
      for (int i = 0; i < 4; i++) begin
         acc_op_sel      = 2'd3;
         acc_addr_offset = 32'(4 * i);
         acc_wdata       = 32'(i + 1);
         acc_wen         = 1'b1;
         @(negedge clk);
      end
      acc_wen = 1'b0;
      done_idle = 1'b0;
      for (int k = 0; k < 60 && !done_idle; k++) begin
         @(negedge clk);
         if (idle) done_idle = 1'b1;
      end
      gnt_delay = 0;
      vectors++; if (done_idle !== 1'b1) begin miscompares++; $display("FAIL wr_idle got %b exp 1", done_idle); end
      vectors++; if (wlog_addr.size() - wbase !== 4) begin miscompares++; $display("FAIL wr_count got %0d exp 4", wlog_addr.size() - wbase); end
      for (int i = 0; i < 4 && wbase + i < wlog_addr.size(); i++) begin
         vectors++; if (wlog_addr[wbase + i] !== 32'h2000 + 32'(4 * i)) begin miscompares++; $display("FAIL wr_addr_%0d got %h exp %h", i, wlog_addr[wbase + i], 32'h2000 + 32'(4 * i)); end
         vectors++; if (wlog_data[wbase + i] !== 32'(i + 1)) begin miscompares++; $display("FAIL wr_data_%0d got %h exp %h", i, wlog_data[wbase + i], 32'(i + 1)); end
      end
      vectors++; if (wbuf_overflow !== 1'b0) begin miscompares++; $display("FAIL wr_ovf got %b exp 0", wbuf_overflow); end
   endtask

   task automatic test_read_after_write();
      int   wbase, rbase;
      logic seen;
      set_base(2'd2, 32'h0000_3000);
      gnt_delay = 1;
      wbase = wlog_addr.size();
      rbase = rlog_addr.size();
      acc_op_sel      = 2'd2;
      acc_addr_offset = 32'h0;
      acc_wdata       = 32'hA5A5_0001;
      acc_wen         = 1'b1;
      @(negedge clk);
      acc_wdata       = 32'h5A5A_0002;
      @(negedge clk);
      acc_wen         = 1'b0;
      acc_ren         = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (acc_done) seen = 1'b1;
      end
      acc_ren   = 1'b0;
      gnt_delay = 0;
      vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL raw_timeout got %b exp 1", seen); end
      vectors++; if (acc_rdata !== 32'h5A5A_0002) begin miscompares++; $display("FAIL raw_data got %h exp 5a5a0002", acc_rdata); end
      vectors++; if (rd_after_writes !== wbase + 2) begin miscompares++; $display("FAIL raw_order got %0d exp %0d", rd_after_writes, wbase + 2); end
      vectors++; if (rlog_addr.size() - rbase !== 1) begin miscompares++; $display("FAIL raw_reads got %0d exp 1", rlog_addr.size() - rbase); end
   endtask

   task automatic test_overflow();
      int   wbase;
      logic done_idle;
      gnt_en = 1'b0;
      wbase = wlog_addr.size();
      @(negedge clk);
      for (int i = 0; i <= WBUF_DEPTH; i++) begin
         if (i == WBUF_DEPTH) begin
            vectors++; if (wbuf_overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early got %b exp 0", wbuf_overflow); end
         end
         acc_op_sel      = 2'd3;
         acc_addr_offset = 32'h40 + 32'(4 * i);
         acc_wdata       = 32'h100 + 32'(i);
         acc_wen         = 1'b1;
         @(negedge clk);
      end
      acc_wen = 1'b0;
      vectors++; if (wbuf_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b exp 1", wbuf_overflow); end
      vectors++; if (wlog_addr.size() - wbase !== 0) begin miscompares++; $display("FAIL ovf_nogrant got %0d exp 0", wlog_addr.size() - wbase); end
      gnt_en = 1'b1;
      done_idle = 1'b0;
      for (int k = 0; k < 60 && !done_idle; k++) begin
         @(negedge clk);
         if (idle) done_idle = 1'b1;
      end
      vectors++; if (done_idle !== 1'b1) begin miscompares++; $display("FAIL ovf_idle got %b exp 1", done_idle); end
      vectors++; if (wlog_addr.size() - wbase !== WBUF_DEPTH) begin miscompares++; $display("FAIL ovf_count got %0d exp %0d", wlog_addr.size() - wbase, WBUF_DEPTH); end
      for (int i = 0; i < WBUF_DEPTH && wbase + i < wlog_addr.size(); i++) begin
         vectors++; if (wlog_addr[wbase + i] !== 32'h2040 + 32'(4 * i)) begin miscompares++; $display("FAIL ovf_addr_%0d got %h exp %h", i, wlog_addr[wbase + i], 32'h2040 + 32'(4 * i)); end
         vectors++; if (wlog_data[wbase + i] !== 32'h100 + 32'(i)) begin miscompares++; $display("FAIL ovf_data_%0d got %h exp %h", i, wlog_data[wbase + i], 32'h100 + 32'(i)); end
      end
      vectors++; if (wbuf_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b exp 1", wbuf_overflow); end
   endtask

   task automatic test_reset_mid_read();
      logic stray_done;
      rvalid_en       = 1'b0;
      acc_op_sel      = 2'd1;
      acc_addr_offset = 32'h8;
      acc_ren         = 1'b1;
      @(negedge clk);
      vectors++; if (dmem_req !== 1'b1) begin miscompares++; $display("FAIL rst_rdreq got %b exp 1", dmem_req); end
      @(negedge clk);
      vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL rst_rdwait got %b exp 0", dmem_req); end
      acc_ren = 1'b0;
      rst     = 1'b1;
      #1;
      vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b exp 0", dmem_req); end
      vectors++; if (acc_done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b exp 0", acc_done); end
      vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL rst_idle got %b exp 1", idle); end
      vectors++; if (wbuf_overflow !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got %b exp 0", wbuf_overflow); end
      @(negedge clk);
      rst       = 1'b0;
      rvalid_en = 1'b1;
      stray_done = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (acc_done) stray_done = 1'b1;
      end
      vectors++; if (stray_done !== 1'b0) begin miscompares++; $display("FAIL rst_stray_done got %b exp 0", stray_done); end
      vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL rst_idle_after got %b exp 1", idle); end
   endtask

   initial begin
      rst = 1'b1;
      base_we = 1'b0; base_sel = '0; base_data = '0;
      acc_ren = 1'b0; acc_wen = 1'b0; acc_type = 2'b00;
      acc_addr_offset = '0; acc_op_sel = '0; acc_wdata = '0;
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      test_reset();
      test_single_read();
      test_back_to_back();
      test_write_burst();
      test_read_after_write();
      test_overflow();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
